// File: rtl/regfile_scoreboard_if.sv
// Issue, writeback and read-port bundle for regfile_scoreboard.
// The master side is the issuing pipeline; the slave side is the register file.
interface regfile_scoreboard_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int READ_PORTS = 2
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                          issue_valid;
    logic [TAG_W-1:0]              issue_rd;
    logic                          issue_ready;
    logic                          wb_valid;
    logic [TAG_W-1:0]              wb_rd;
    logic [WIDTH-1:0]              wb_data;
    logic [READ_PORTS*TAG_W-1:0]   rs_addr;
    logic [READ_PORTS*WIDTH-1:0]   rs_data;
    logic [READ_PORTS-1:0]         rs_busy;
    logic                          wb_error;

    modport master (
        output issue_valid, issue_rd, wb_valid, wb_rd, wb_data, rs_addr,
        input  issue_ready, rs_data, rs_busy, wb_error
    );

    modport slave (
        input  issue_valid, issue_rd, wb_valid, wb_rd, wb_data, rs_addr,
        output issue_ready, rs_data, rs_busy, wb_error
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters and combinational read ports.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback onto matching read ports.
module regfile_scoreboard #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int READ_PORTS = 2,
    parameter int PEND_BITS  = 2
) (
    input logic                clock,
    input logic                reset_n,
    regfile_scoreboard_if.slave bus
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam logic [PEND_BITS-1:0] PEND_MAX = '1;
    localparam logic [PEND_BITS-1:0] PEND_ONE = PEND_BITS'(1);

    logic [WIDTH-1:0]     regs_q [DEPTH];
    logic [WIDTH-1:0]     regs_d [DEPTH];
    logic [PEND_BITS-1:0] cnt_q  [DEPTH];
    logic [PEND_BITS-1:0] cnt_d  [DEPTH];
    logic                 wb_error_q;
    logic                 wb_error_d;

    logic issue_ready;
    logic issue_inc;
    logic wb_write;
    logic wb_dec;
    logic same_reg;

    logic [TAG_W-1:0]            rs_tag [READ_PORTS];
    logic [READ_PORTS*WIDTH-1:0] rs_data_c;
    logic [READ_PORTS-1:0]       rs_busy_c;

    always_comb begin
        issue_ready = (bus.issue_rd == '0) || (cnt_q[bus.issue_rd] != PEND_MAX);
        issue_inc   = bus.issue_valid && issue_ready && (bus.issue_rd != '0);
        wb_write    = bus.wb_valid && (bus.wb_rd != '0);
        wb_dec      = wb_write && (cnt_q[bus.wb_rd] != '0);
        same_reg    = (bus.issue_rd == bus.wb_rd);
    end

    // Issue and retire on the same register cancel, so the counter never moves.
    always_comb begin
        regs_d     = regs_q;
        cnt_d      = cnt_q;
        wb_error_d = wb_error_q;
        if (wb_write) begin
            regs_d[bus.wb_rd] = bus.wb_data;
            if (cnt_q[bus.wb_rd] == '0) begin
                wb_error_d = 1'b1;
            end
        end
        if (issue_inc && !(wb_dec && same_reg)) begin
            cnt_d[bus.issue_rd] = cnt_q[bus.issue_rd] + PEND_ONE;
        end
        if (wb_dec && !(issue_inc && same_reg)) begin
            cnt_d[bus.wb_rd] = cnt_q[bus.wb_rd] - PEND_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            wb_error_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            cnt_q      <= cnt_d;
            wb_error_q <= wb_error_d;
        end
    end

    always_comb begin
        rs_tag = '{default: '0};
        for (int p = 0; p < READ_PORTS; p++) begin
            rs_tag[p] = bus.rs_addr[p*TAG_W +: TAG_W];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [READ_PORTS-1:0] rs_hit;

    // Forwarding is gated by reset_n so outputs hold zero while reset is asserted.
    always_comb begin
        rs_data_c = '0;
        rs_busy_c = '0;
        rs_hit    = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rs_hit[p] = reset_n && wb_write && (bus.wb_rd == rs_tag[p]);
            rs_data_c[p*WIDTH +: WIDTH] = rs_hit[p] ? bus.wb_data : regs_q[rs_tag[p]];
            rs_busy_c[p] = (rs_tag[p] != '0) &&
                           ((cnt_q[rs_tag[p]] - ((rs_hit[p] && wb_dec) ? PEND_ONE : '0)) != '0);
        end
    end
`else
    always_comb begin
        rs_data_c = '0;
        rs_busy_c = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rs_data_c[p*WIDTH +: WIDTH] = regs_q[rs_tag[p]];
            rs_busy_c[p] = (rs_tag[p] != '0) && (cnt_q[rs_tag[p]] != '0);
        end
    end
`endif

    assign bus.issue_ready = issue_ready;
    assign bus.rs_data     = rs_data_c;
    assign bus.rs_busy     = rs_busy_c;
    assign bus.wb_error    = wb_error_q;

endmodule
